irq_controller: RTL

- Downstream consumer of the per-source interrupt edge detectors.
- Collects NUM_SRC latched interrupt flags and applies per-source and global enables.
- Selects the highest-priority pending source, raises a request to the CPU with its ID and ISR address, and waits for the request to be acknowledged and for end-of-interrupt.
- On acknowledge, pulses the clear line back to the selected source's detector (its interrupt_flag_set_0 input).

---
 rtl/irq_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: arbitrates latched source flags, requests the CPU,
// and returns a one-hot clear pulse to the selected detector on acknowledge.
module irq_controller #(
    parameter int                  NUM_SRC       = 8,
    parameter int                  ID_W          = 3,
    parameter int                  ADDR_W        = 32,
    parameter logic [ADDR_W-1:0]   VECTOR_BASE   = 32'h0000_0100,
    parameter int                  VECTOR_STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   irq_flags,
    input  logic [NUM_SRC-1:0]   src_enable,
    input  logic                 global_enable,
    output logic                 irq_req,
    output logic [ID_W-1:0]      irq_id,
    output logic [ADDR_W-1:0]    isr_addr,
    input  logic                 irq_ack,
    input  logic                 eoi,
    output logic [NUM_SRC-1:0]   flag_clear,
    output logic                 in_service,
    output logic [NUM_SRC-1:0]   pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(VECTOR_STRIDE);

    state_t               state_reg,      state_next;
    logic                 irq_req_reg,    irq_req_next;
    logic [ID_W-1:0]      irq_id_reg,     irq_id_next;
    logic [ADDR_W-1:0]    isr_addr_reg,   isr_addr_next;
    logic [NUM_SRC-1:0]   flag_clear_reg, flag_clear_next;
    logic                 in_service_reg, in_service_next;

    logic [NUM_SRC-1:0]   masked;
    logic [NUM_SRC:0]     found_below;
    logic [NUM_SRC-1:0]   winner_onehot;
    logic [NUM_SRC-1:0]   id_decode;
    logic [ID_W-1:0]      winner_id;
    logic                 any_pending;
    logic                 id_still_pending;

    assign masked      = irq_flags & src_enable;
    assign any_pending = |masked;

    // found_below[i] is set when some source with index < i is pending, so the
    // lowest-index pending source is the only one left in winner_onehot.
    assign found_below[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_prio
            assign winner_onehot[gi]   = masked[gi] & ~found_below[gi];
            assign found_below[gi + 1] = found_below[gi] | masked[gi];
            assign id_decode[gi]       = (irq_id_reg == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        winner_id = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winner_onehot[i]) begin
                winner_id = winner_id | ID_W'(i);
            end
        end
    end

    // Decoded compare avoids indexing masked[] with an ID that may be wider than the vector.
    assign id_still_pending = |(masked & id_decode);

    always_comb begin
        state_next      = state_reg;
        irq_req_next    = irq_req_reg;
        irq_id_next     = irq_id_reg;
        isr_addr_next   = isr_addr_reg;
        in_service_next = in_service_reg;
        flag_clear_next = '0;

        case (state_reg)
            IDLE: begin
                if (global_enable && any_pending) begin
                    state_next    = REQUEST;
                    irq_req_next  = 1'b1;
                    irq_id_next   = winner_id;
                    isr_addr_next = VECTOR_BASE + (ADDR_W'(winner_id) * STRIDE_W);
                end
            end

            REQUEST: begin
                // Acknowledge takes precedence over a simultaneous withdrawal.
                if (irq_ack) begin
                    state_next      = SERVICE;
                    irq_req_next    = 1'b0;
                    in_service_next = 1'b1;
                    flag_clear_next = id_decode;
                end else if (!id_still_pending || !global_enable) begin
                    state_next   = IDLE;
                    irq_req_next = 1'b0;
                end
            end

            SERVICE: begin
                if (eoi) begin
                    state_next      = IDLE;
                    in_service_next = 1'b0;
                end
            end

            default: begin
                state_next      = IDLE;
                irq_req_next    = 1'b0;
                in_service_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            irq_req_reg    <= 1'b0;
            irq_id_reg     <= '0;
            isr_addr_reg   <= '0;
            flag_clear_reg <= '0;
            in_service_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            irq_req_reg    <= irq_req_next;
            irq_id_reg     <= irq_id_next;
            isr_addr_reg   <= isr_addr_next;
            flag_clear_reg <= flag_clear_next;
            in_service_reg <= in_service_next;
        end
    end

    assign irq_req    = irq_req_reg;
    assign irq_id     = irq_id_reg;
    assign isr_addr   = isr_addr_reg;
    assign flag_clear = flag_clear_reg;
    assign in_service = in_service_reg;
    assign pending    = masked;

endmodule
